// File: rtl/axis_tid_stats.sv
// AXI4-Stream skid-buffered pass-through with per-source byte/frame/error counters
// decoded from the upper tid bits. Define AXIS_TID_STATS_SAT_EN for saturating counters.
module axis_tid_stats #(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int ID_WIDTH    = 8 + $clog2(S_COUNT),
  parameter int USER_WIDTH  = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [DATA_WIDTH-1:0]                         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]                         s_axis_tkeep,
  input  logic                                          s_axis_tvalid,
  output logic                                          s_axis_tready,
  input  logic                                          s_axis_tlast,
  input  logic [ID_WIDTH-1:0]                           s_axis_tid,
  input  logic [USER_WIDTH-1:0]                         s_axis_tuser,
  output logic [DATA_WIDTH-1:0]                         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]                         m_axis_tkeep,
  output logic                                          m_axis_tvalid,
  input  logic                                          m_axis_tready,
  output logic                                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]                           m_axis_tid,
  output logic [USER_WIDTH-1:0]                         m_axis_tuser,
  input  logic [((S_COUNT > 1) ? $clog2(S_COUNT) : 1)-1:0] stat_sel,
  input  logic                                          stat_clear,
  output logic [CNT_WIDTH-1:0]                          stat_bytes,
  output logic [CNT_WIDTH-1:0]                          stat_frames,
  output logic [CNT_WIDTH-1:0]                          stat_errors
);

  localparam int CL_S_COUNT = $clog2(S_COUNT);
  localparam int SEL_W      = (CL_S_COUNT > 0) ? CL_S_COUNT : 1;
  localparam int N_SLOT     = 2 ** SEL_W;
  localparam int BEAT_W     = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + USER_WIDTH;

  // Handshake: a beat transfers on any rising clk edge where tvalid && tready;
  // a source holds tvalid and its payload stable until that edge.

  logic [KEEP_WIDTH-1:0] keep_in;
  logic [BEAT_W-1:0]     beat_in;
  logic [BEAT_W-1:0]     m_beat_reg;
  logic [BEAT_W-1:0]     temp_beat_reg;
  logic                  s_ready_reg;
  logic                  m_valid_reg;
  logic                  temp_valid_reg;
  logic                  s_ready_next;
  logic                  m_valid_next;
  logic                  temp_valid_next;
  logic                  store_in_to_out;
  logic                  store_in_to_temp;
  logic                  store_temp_to_out;
  logic                  s_accept;

  assign keep_in  = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
  assign beat_in  = {s_axis_tdata, keep_in, s_axis_tlast, s_axis_tid, s_axis_tuser};
  assign s_accept = s_axis_tvalid && s_ready_reg;

  assign s_axis_tready = s_ready_reg;
  assign m_axis_tvalid = m_valid_reg;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tuser} = m_beat_reg;

  always_comb begin
    m_valid_next      = m_valid_reg;
    temp_valid_next   = temp_valid_reg;
    store_in_to_out   = 1'b0;
    store_in_to_temp  = 1'b0;
    store_temp_to_out = 1'b0;
    s_ready_next      = m_axis_tready || (!temp_valid_reg && (!m_valid_reg || !s_accept));
    if (s_ready_reg) begin
      if (m_axis_tready || !m_valid_reg) begin
        m_valid_next    = s_axis_tvalid;
        store_in_to_out = 1'b1;
      end else begin
        temp_valid_next  = s_axis_tvalid;
        store_in_to_temp = 1'b1;
      end
    end else if (m_axis_tready) begin
      m_valid_next      = temp_valid_reg;
      temp_valid_next   = 1'b0;
      store_temp_to_out = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready_reg    <= 1'b0;
      m_valid_reg    <= 1'b0;
      temp_valid_reg <= 1'b0;
    end else begin
      s_ready_reg    <= s_ready_next;
      m_valid_reg    <= m_valid_next;
      temp_valid_reg <= temp_valid_next;
    end
  end

  // Payload registers carry no reset; the valid flags qualify them.
  always_ff @(posedge clk) begin
    if (store_in_to_out) begin
      m_beat_reg <= beat_in;
    end else if (store_temp_to_out) begin
      m_beat_reg <= temp_beat_reg;
    end
    if (store_in_to_temp) begin
      temp_beat_reg <= beat_in;
    end
  end

  logic [SEL_W-1:0] src;

  generate
    if (CL_S_COUNT > 0) begin : g_src_tid
      assign src = s_axis_tid[ID_WIDTH-1 -: CL_S_COUNT];
    end else begin : g_src_zero
      assign src = '0;
    end
  endgenerate

  function automatic logic [CNT_WIDTH-1:0] cnt_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
`ifdef AXIS_TID_STATS_SAT_EN
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  logic [CNT_WIDTH-1:0] byte_inc;
  logic [N_SLOT-1:0]    clr_vec;
  logic [N_SLOT-1:0]    hit_vec;
  logic [CNT_WIDTH-1:0] bytes_cnt   [N_SLOT];
  logic [CNT_WIDTH-1:0] frames_cnt  [N_SLOT];
  logic [CNT_WIDTH-1:0] errors_cnt  [N_SLOT];
  logic [CNT_WIDTH-1:0] bytes_next  [N_SLOT];
  logic [CNT_WIDTH-1:0] frames_next [N_SLOT];
  logic [CNT_WIDTH-1:0] errors_next [N_SLOT];

  always_comb begin
    byte_inc = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      byte_inc = byte_inc + CNT_WIDTH'(keep_in[i]);
    end
  end

  // Slots at or above S_COUNT never match, so out-of-range sources count nowhere.
  always_comb begin
    clr_vec = '0;
    hit_vec = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      clr_vec[i] = stat_clear && (stat_sel == SEL_W'(i));
      hit_vec[i] = (i < S_COUNT) && s_accept && (src == SEL_W'(i));
    end
  end

  // Clear first, then add the same-cycle beat on top of the cleared value.
  always_comb begin
    for (int i = 0; i < N_SLOT; i++) begin
      bytes_next[i]  = clr_vec[i] ? '0 : bytes_cnt[i];
      frames_next[i] = clr_vec[i] ? '0 : frames_cnt[i];
      errors_next[i] = clr_vec[i] ? '0 : errors_cnt[i];
      if (hit_vec[i]) begin
        bytes_next[i] = cnt_add(bytes_next[i], byte_inc);
        if (s_axis_tlast) begin
          frames_next[i] = cnt_add(frames_next[i], CNT_WIDTH'(1));
        end
        if (s_axis_tlast && s_axis_tuser[0]) begin
          errors_next[i] = cnt_add(errors_next[i], CNT_WIDTH'(1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SLOT; i++) begin
        bytes_cnt[i]  <= '0;
        frames_cnt[i] <= '0;
        errors_cnt[i] <= '0;
      end
      stat_bytes  <= '0;
      stat_frames <= '0;
      stat_errors <= '0;
    end else begin
      for (int i = 0; i < N_SLOT; i++) begin
        bytes_cnt[i]  <= bytes_next[i];
        frames_cnt[i] <= frames_next[i];
        errors_cnt[i] <= errors_next[i];
      end
      stat_bytes  <= bytes_cnt[stat_sel];
      stat_frames <= frames_cnt[stat_sel];
      stat_errors <= errors_cnt[stat_sel];
    end
  end

endmodule

// File: tb/tb_axis_tid_stats.sv
// Self-checking bench for axis_tid_stats: scoreboarded pass-through plus a counter
// model; a second narrow-counter instance covers wrap/saturation.
module tb_axis_tid_stats;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int IW = 10;
  localparam int UW = 1;
  localparam int CW = 32;
  localparam int NS = 4;
  localparam int BW = DW + KW + 1 + IW + UW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata  = '0;
  logic [KW-1:0] s_tkeep  = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast  = 1'b0;
  logic [IW-1:0] s_tid    = '0;
  logic [UW-1:0] s_tuser  = '0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [IW-1:0] m_tid;
  logic [UW-1:0] m_tuser;
  logic [1:0]    stat_sel   = '0;
  logic          stat_clear = 1'b0;
  logic [CW-1:0] stat_bytes;
  logic [CW-1:0] stat_frames;
  logic [CW-1:0] stat_errors;
  logic [BW-1:0] m_beat;

  assign m_beat = {m_tdata, m_tkeep, m_tlast, m_tid, m_tuser};

  axis_tid_stats #(
    .S_COUNT(NS), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .CNT_WIDTH(CW)
  ) u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tuser(m_tuser),
    .stat_sel(stat_sel), .stat_clear(stat_clear),
    .stat_bytes(stat_bytes), .stat_frames(stat_frames), .stat_errors(stat_errors)
  );

  // narrow-counter instance
  logic [15:0] w_s_tdata  = '0;
  logic [1:0]  w_s_tkeep  = '0;
  logic        w_s_tvalid = 1'b0;
  logic        w_s_tready;
  logic        w_s_tlast  = 1'b0;
  logic [9:0]  w_s_tid    = '0;
  logic [0:0]  w_s_tuser  = '0;
  logic [15:0] w_m_tdata;
  logic [1:0]  w_m_tkeep;
  logic        w_m_tvalid;
  logic        w_m_tlast;
  logic [9:0]  w_m_tid;
  logic [0:0]  w_m_tuser;
  logic [3:0]  w_stat_bytes;
  logic [3:0]  w_stat_frames;
  logic [3:0]  w_stat_errors;
  int          w_out_count = 0;

  axis_tid_stats #(
    .S_COUNT(4), .DATA_WIDTH(16), .ID_WIDTH(10), .USER_WIDTH(1), .CNT_WIDTH(4)
  ) u_dut_w4 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(w_s_tdata), .s_axis_tkeep(w_s_tkeep), .s_axis_tvalid(w_s_tvalid),
    .s_axis_tready(w_s_tready), .s_axis_tlast(w_s_tlast), .s_axis_tid(w_s_tid),
    .s_axis_tuser(w_s_tuser),
    .m_axis_tdata(w_m_tdata), .m_axis_tkeep(w_m_tkeep), .m_axis_tvalid(w_m_tvalid),
    .m_axis_tready(1'b1), .m_axis_tlast(w_m_tlast), .m_axis_tid(w_m_tid),
    .m_axis_tuser(w_m_tuser),
    .stat_sel(2'd0), .stat_clear(1'b0),
    .stat_bytes(w_stat_bytes), .stat_frames(w_stat_frames), .stat_errors(w_stat_errors)
  );

  // scoreboard state
  int            n_checks = 0;
  int            n_errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [CW-1:0] mdl_bytes  [NS];
  logic [CW-1:0] mdl_frames [NS];
  logic [CW-1:0] mdl_errors [NS];
  int            ready_mode = 0;
  bit            saw_stall  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // m_tready pattern driver: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       begin m_tready = ((ph % 4) == 0) || ((ph % 4) == 3); ph++; end
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // output monitor: in-order compare and stall-stability check
  initial begin
    logic          held;
    logic [BW-1:0] held_beat;
    held = 1'b0;
    held_beat = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (held) begin
          check("hold_valid", 64'(m_tvalid), 64'd1);
          check("hold_beat", 64'(m_beat), 64'(held_beat));
        end
        held = 1'b0;
        if (m_tvalid) begin
          if (m_tready) begin
            check("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("beat", 64'(m_beat), 64'(exp_q.pop_front()));
          end else begin
            held = 1'b1;
            held_beat = m_beat;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && w_m_tvalid) w_out_count++;
    end
  end

  task automatic send_beat(input int src, input logic [DW-1:0] data, input logic [KW-1:0] keep,
                           input logic last, input logic user, input logic clr);
    int            w;
    logic [IW-1:0] tid;
    w   = 0;
    tid = {2'(src), 8'($urandom_range(0, 255))};
    s_tdata  = data;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tid    = tid;
    s_tuser  = user;
    s_tvalid = 1'b1;
    if (clr) begin
      stat_sel   = 2'(src);
      stat_clear = 1'b1;
    end
    forever begin
      @(negedge clk);
      if (s_tready) break;
      saw_stall = 1'b1;
      w++;
      if (w > 200) begin
        check("accept_timeout", 64'd0, 64'd1);
        s_tvalid   = 1'b0;
        stat_clear = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back({data, keep, last, tid, user});
    if (clr) begin
      mdl_bytes[src]  = '0;
      mdl_frames[src] = '0;
      mdl_errors[src] = '0;
    end
    mdl_bytes[src] = mdl_bytes[src] + CW'($countones(keep));
    if (last) mdl_frames[src] = mdl_frames[src] + 1'b1;
    if (last && user) mdl_errors[src] = mdl_errors[src] + 1'b1;
    #1;
    s_tvalid   = 1'b0;
    stat_clear = 1'b0;
  endtask

  task automatic check_stats(input int src);
    stat_sel = 2'(src);
    @(posedge clk);
    #1;
    check($sformatf("bytes_src%0d", src), 64'(stat_bytes), 64'(mdl_bytes[src]));
    check($sformatf("frames_src%0d", src), 64'(stat_frames), 64'(mdl_frames[src]));
    check($sformatf("errors_src%0d", src), 64'(stat_errors), 64'(mdl_errors[src]));
  endtask

  task automatic drain(input string tag);
    ready_mode = 0;
    repeat (12) @(posedge clk);
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [3:0] w_exp;
    for (int i = 0; i < NS; i++) begin
      mdl_bytes[i]  = '0;
      mdl_frames[i] = '0;
      mdl_errors[i] = '0;
    end

    // reset and idle
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 64'(m_tvalid), 64'd0);
    check("rst_s_ready", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(s_tready), 64'd1);
    check("idle_m_valid", 64'(m_tvalid), 64'd0);
    for (int s = 0; s < NS; s++) check_stats(s);

    // one 3-beat frame on source 2, latency 1
    send_beat(2, 32'h11223344, 4'hF, 1'b0, 1'b0, 1'b0);
    check("lat_valid", 64'(m_tvalid), 64'd1);
    check("lat_data", 64'(m_tdata), 64'h11223344);
    send_beat(2, 32'h55667788, 4'hF, 1'b0, 1'b0, 1'b0);
    send_beat(2, 32'h99aabbcc, 4'h3, 1'b1, 1'b0, 1'b0);
    drain("t2_drain");
    check_stats(2);
    check("t2_bytes10", 64'(stat_bytes), 64'd10);
    for (int s = 0; s < NS; s++) if (s != 2) check_stats(s);

    // back-to-back frames on source 1 with output stalls
    ready_mode = 1;
    saw_stall  = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 3; b++) begin
        send_beat(1, DW'($urandom), 4'($urandom_range(1, 15)), 1'(b == 2), 1'b0, 1'b0);
      end
    end
    drain("t3_drain");
    check("t3_ready_dropped", 64'(saw_stall), 64'd1);
    check_stats(1);

    // bad frame on source 3
    send_beat(3, 32'hdeadbeef, 4'hF, 1'b0, 1'b0, 1'b0);
    send_beat(3, 32'h0badf00d, 4'h1, 1'b1, 1'b1, 1'b0);
    drain("t4_drain");
    check_stats(3);
    check("t4_errors1", 64'(stat_errors), 64'd1);

    // clear coinciding with an accepted beat on the same source
    for (int b = 0; b < 25; b++) send_beat(0, DW'(b), 4'hF, 1'b0, 1'b0, 1'b0);
    check_stats(0);
    check("t5_bytes100", 64'(stat_bytes), 64'd100);
    send_beat(0, 32'hc1ea4000, 4'hF, 1'b1, 1'b0, 1'b1);
    check("t5_read_pre_update", 64'(stat_bytes), 64'd100);
    check_stats(0);
    check("t5_bytes4", 64'(stat_bytes), 64'd4);
    check("t5_frames1", 64'(stat_frames), 64'd1);
    for (int s = 1; s < NS; s++) check_stats(s);

    // random traffic with random output backpressure and occasional clears
    ready_mode = 2;
    for (int b = 0; b < 80; b++) begin
      send_beat($urandom_range(0, NS - 1), DW'($urandom), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 9) == 0));
    end
    drain("rand_drain");
    for (int s = 0; s < NS; s++) check_stats(s);

    // narrow counters: ten 2-byte beats on source 0
    for (int b = 0; b < 10; b++) begin
      int w;
      w = 0;
      w_s_tdata  = 16'($urandom);
      w_s_tkeep  = 2'b11;
      w_s_tlast  = 1'(b == 9);
      w_s_tid    = 10'd0;
      w_s_tvalid = 1'b1;
      forever begin
        @(negedge clk);
        if (w_s_tready) break;
        w++;
        if (w > 50) begin
          check("w4_accept_timeout", 64'd0, 64'd1);
          break;
        end
      end
      @(posedge clk);
      #1;
      w_s_tvalid = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
`ifdef AXIS_TID_STATS_SAT_EN
    w_exp = 4'd15;
`else
    w_exp = 4'd4;
`endif
    check("w4_bytes", 64'(w_stat_bytes), 64'(w_exp));
    check("w4_frames", 64'(w_stat_frames), 64'd1);
    check("w4_out_beats", 64'(w_out_count), 64'd10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
